// File: rtl/agnus_blitter_shiftpipe_if.sv
// Source-word stream bus between the A/B source channels, the shift pipe and the minterm logic.
interface agnus_blitter_shiftpipe_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned SHW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_first;
  logic           in_last;
  logic           desc;
  logic [SHW-1:0] shift;
  logic [DW-1:0]  fwm;
  logic [DW-1:0]  lwm;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_first;
  logic           out_last;
  logic           clr_zero;
  logic           zero;

  modport master (
    output in_valid, in_data, in_first, in_last, desc, shift, fwm, lwm,
           out_ready, clr_zero,
    input  in_ready, out_valid, out_data, out_first, out_last, zero
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, desc, shift, fwm, lwm,
           out_ready, clr_zero,
    output in_ready, out_valid, out_data, out_first, out_last, zero
  );
endinterface

// File: rtl/agnus_blitter_shiftpipe.sv
// Pipelined blitter source shifter: masks, shifts with carry from the previous word of the
// line, and tracks the blitter zero flag. One output register, one word per cycle.
module agnus_blitter_shiftpipe #(
  parameter int unsigned DW  = 16,
  parameter int unsigned SHW = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  agnus_blitter_shiftpipe_if.slave    bus
);

  logic           out_valid_q;
  logic [DW-1:0]  out_data_q;
  logic           out_first_q;
  logic           out_last_q;
  logic           zero_q;
  logic [DW-1:0]  carry_q;
  logic           desc_q;
  logic [SHW-1:0] shift_q;

  logic           in_ready_c;
  logic           acc_c;
  logic [DW-1:0]  m_c;
  logic [DW-1:0]  p_c;
  logic           desc_eff_c;
  logic [SHW-1:0] shift_eff_c;
  logic [DW-1:0]  r_c;

  assign in_ready_c   = !out_valid_q | bus.out_ready;
  assign acc_c        = bus.in_valid & in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.zero      = zero_q;

  // Mask, pick the effective mode, and shift the {carry, word} pair.
  // Shifting the concatenation keeps s=0 a pass-through and never shifts by DW.
  always_comb begin
    m_c         = bus.in_data
                & (bus.in_first ? bus.fwm : {DW{1'b1}})
                & (bus.in_last  ? bus.lwm : {DW{1'b1}});
    p_c         = bus.in_first ? {DW{1'b0}} : carry_q;
    desc_eff_c  = bus.in_first ? bus.desc  : desc_q;
    shift_eff_c = bus.in_first ? bus.shift : shift_q;
    if (desc_eff_c) begin
      r_c = DW'(({m_c, p_c} << shift_eff_c) >> DW);
    end else begin
      r_c = DW'({p_c, m_c} >> shift_eff_c);
    end
  end

  // Carry, mode latch and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_q     <= '0;
      desc_q      <= 1'b0;
      shift_q     <= '0;
    end else begin
      if (acc_c) begin
        carry_q     <= m_c;
        out_valid_q <= 1'b1;
        out_data_q  <= r_c;
        out_first_q <= bus.in_first;
        out_last_q  <= bus.in_last;
        if (bus.in_first) begin
          desc_q  <= bus.desc;
          shift_q <= bus.shift;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Zero flag; a new blit's clear wins over a concurrent nonzero word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else if (bus.clr_zero) begin
      zero_q <= 1'b1;
    end else if (acc_c && (r_c != '0)) begin
      zero_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_agnus_blitter_shiftpipe.sv
// Directed bench for the blitter shift pipe with hand-computed expected words.
module tb_agnus_blitter_shiftpipe;

  localparam int unsigned DW  = 16;
  localparam int unsigned SHW = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  agnus_blitter_shiftpipe_if #(.DW(DW), .SHW(SHW)) bus ();

  agnus_blitter_shiftpipe #(.DW(DW), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word with out_ready=1, then check the registered result one cycle later.
  task automatic send(input string tag, input logic [15:0] data, input logic first,
                      input logic last, input logic [15:0] exp);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_first  = first;
    bus.in_last   = last;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'h1);
    chk({tag, "_data"},  bus.out_data, exp);
    chk({tag, "_flags"}, 16'({bus.out_first, bus.out_last}), 16'({first, last}));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", 16'(bus.out_valid), 16'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.desc      = 1'b0;
    bus.shift     = '0;
    bus.fwm       = 16'hFFFF;
    bus.lwm       = 16'hFFFF;
    bus.out_ready = 1'b1;
    bus.clr_zero  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_data",  bus.out_data, 16'h0000);
    chk("rst_zero",  16'(bus.zero), 16'h1);
    chk("rst_ready", 16'(bus.in_ready), 16'h1);

    // Ascending, shift 4
    bus.desc  = 1'b0;
    bus.shift = 4'd4;
    send("asc0", 16'h1234, 1'b1, 1'b0, 16'h0123);
    send("asc1", 16'h5678, 1'b0, 1'b0, 16'h4567);
    send("asc2", 16'h9ABC, 1'b0, 1'b1, 16'h89AB);
    chk("asc_zero", 16'(bus.zero), 16'h0);
    idle();

    // Descending, shift 4
    bus.desc  = 1'b1;
    send("dsc0", 16'h1234, 1'b1, 1'b0, 16'h2340);
    send("dsc1", 16'h5678, 1'b0, 1'b0, 16'h6781);
    send("dsc2", 16'h9ABC, 1'b0, 1'b1, 16'hABC5);
    idle();

    // Masks and zero flag
    @(negedge clk);
    bus.clr_zero = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_zero = 1'b0;
    chk("clr_zero", 16'(bus.zero), 16'h1);
    bus.fwm   = 16'h00FF;
    bus.lwm   = 16'hFF00;
    bus.desc  = 1'b0;
    bus.shift = 4'd0;
    send("msk_single", 16'hFFFF, 1'b1, 1'b1, 16'h0000);
    chk("msk_single_zero", 16'(bus.zero), 16'h1);
    bus.shift = 4'd8;
    send("msk_l0", 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    chk("msk_l0_zero", 16'(bus.zero), 16'h1);
    send("msk_l1", 16'hFFFF, 1'b0, 1'b1, 16'hFFFF);
    chk("msk_l1_zero", 16'(bus.zero), 16'h0);
    idle();

    // Backpressure mid-line
    bus.fwm   = 16'hFFFF;
    bus.lwm   = 16'hFFFF;
    bus.shift = 4'd4;
    send("bp0", 16'h1234, 1'b1, 1'b0, 16'h0123);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h5678;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("bp_ready", 16'(bus.in_ready), 16'h0);
      @(posedge clk);
      #1;
      chk("bp_hold_data",  bus.out_data, 16'h0123);
      chk("bp_hold_valid", 16'(bus.out_valid), 16'h1);
    end
    send("bp1", 16'h5678, 1'b0, 1'b0, 16'h4567);
    send("bp2", 16'h9ABC, 1'b0, 1'b1, 16'h89AB);
    idle();

    // Mid-line shift change is ignored; clr_zero wins over a nonzero accept
    bus.clr_zero = 1'b1;
    send("md0", 16'h1234, 1'b1, 1'b0, 16'h0123);
    bus.clr_zero = 1'b0;
    chk("md0_zero", 16'(bus.zero), 16'h1);
    bus.shift = 4'd8;
    send("md1", 16'h5678, 1'b0, 1'b0, 16'h4567);
    chk("md1_zero", 16'(bus.zero), 16'h0);

    // Reset mid-line
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_valid", 16'(bus.out_valid), 16'h0);
    chk("mrst_zero",  16'(bus.zero), 16'h1);
    @(negedge clk);
    reset = 1'b0;
    bus.shift = 4'd4;
    send("post0", 16'hABCD, 1'b1, 1'b0, 16'h0ABC);
    bus.shift = 4'd0;
    send("post1", 16'h1111, 1'b0, 1'b1, 16'hD111);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agnus_blitter_shiftpipe.md
# agnus_blitter_shiftpipe

Parametrised, pipelined blitter source shifter: the successor to the combinational one-word barrel shifter. It accepts a stream of source words per blit line over a valid/ready handshake and applies first/last-word masks. It keeps the previous word internally as the carry, shifts left or right by 0..DW-1, and tracks the blitter zero flag. It sits between the Agnus blitter source-channel (A/B) data registers and the minterm logic.

## Interface
Parameters:
- DW, 16, data word width; must equal 2**SHW.
- SHW, 4, shift-amount width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  DW  source word.
- in_first  in  1  first word of a line; carry is treated as zero.
- in_last  in  1  last word of a line; may be high together with in_first.
- desc  in  1  descending mode (shift left); sampled only with the first word of a line.
- shift  in  SHW  shift amount; sampled only with the first word of a line.
- fwm  in  DW  first-word mask.
- lwm  in  DW  last-word mask.
- out_valid  out  1  shifted word present.
- out_ready  in  1  consumer takes the output word.
- out_data  out  DW  shifted word.
- out_first, out_last  out  1  the input flags, delayed with the data.
- clr_zero  in  1  sets the zero flag to 1 (start of blit).
- zero  out  1  high while every word output since the last clr_zero or reset was 0.

## Operation
- Accept: acc = in_valid & in_ready.
- in_ready = !out_valid | out_ready. The output stage is a single register, so throughput is one word per cycle.
- Masking happens before shifting. Masked word m = in_data & (in_first ? fwm : all-ones) & (in_last ? lwm : all-ones).
- Mode latch: on an accepted word with in_first=1, desc and shift are captured into mode registers. That same word already uses the new values (effective mode = in_first ? inputs : latched). Changes to desc/shift mid-line are ignored.
- Carry p = in_first ? 0 : carry register. The carry register loads m on every accepted word and holds otherwise.
- Ascending (desc=0), s>0: r = (m >> s) | (p << (DW-s)), truncated to DW bits.
- Descending (desc=1), s>0: r = (m << s) | (p >> (DW-s)), truncated to DW bits.
- s=0: r = m in both modes. The carry contributes nothing, and no shift by DW is ever performed.
- Output register: on accept, out_data←r, out_first/out_last←in flags, out_valid←1. If there is no accept and out_ready=1, out_valid←0. Otherwise all output state holds.
- Zero flag: on an accept with r≠0, zero←0. clr_zero forces zero←1 and has priority over a simultaneous nonzero accept, but that accepted word is still output.
- A line that starts without a prior in_last is legal. in_first alone resets the carry and mode.

## Timing
- Latency: one cycle from accept to out_valid/out_data.
- out_data, out_first and out_last are stable while out_valid=1 and out_ready=0.
- zero updates in the cycle after the accept, concurrently with out_valid.
- Reset values: out_valid=0, out_data=0, out_first=0, out_last=0, zero=1, carry=0, latched desc=0, latched shift=0. in_ready=1 immediately, since it is combinational from out_valid.
- Reset mid-line discards the output word and the carry. The next line must begin with in_first.
- in_valid with out_valid=1 and out_ready=0: no accept, no carry or mode update.

## Test plan
- Reset then idle -> out_valid=0, out_data=0x0000, zero=1, in_ready=1.
- Ascending, shift=4, masks 0xFFFF, words 0x1234(first), 0x5678, 0x9ABC(last), out_ready=1 -> outputs 0x0123, 0x4567, 0x89AB on consecutive cycles, one cycle after each accept; zero=0.
- Descending, shift=4, same words -> 0x2340, 0x6781, 0xABC5.
- Masks: fwm=0x00FF, lwm=0xFF00, clr_zero, then:
  - single word 0xFFFF with first+last, shift=0 -> 0x0000, zero stays 1;
  - then line 0xFFFF(first), 0xFFFF(last), shift=8 ascending -> 0x0000, then 0xFFFF; zero→0 after the second word.
- Backpressure: hold out_ready=0 for 3 cycles mid-line with in_valid=1 -> in_ready=0, out_data constant, no carry change. After release, the output sequence is identical to the unstalled run.
- Change shift 4→8 on the second word of a line -> outputs still use 4. Assert reset mid-line -> out_valid=0 at once, and the next line's first output uses carry=0.
